// File: rtl/stage_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | stage_fetch : PC owner, 1-cycle BRAM fetch, 1-entry skid, epoch flush.     |
// | Optional FETCH_COUNTERS_EN adds fetch/flush counters.       Rev 1.0        |
// +----------------------------------------------------------------------------+
module stage_fetch #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD     = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        reset_i,
  output logic [31:0] imem_addr_o,
  output logic        imem_rd_o,
  input  logic [31:0] imem_data_i,
  input  logic        stall_i,
  input  logic        halt_i,
  input  logic        jmp_valid_i,
  input  logic [31:0] jmp_addr_i,
  output logic        valid_o,
  output logic [31:0] pc_o,
`ifdef FETCH_COUNTERS_EN
  output logic [31:0] ir_o,
  output logic [63:0] fetch_count_o,
  output logic [31:0] flush_count_o
`else
  output logic [31:0] ir_o
`endif
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_STALL = 2'd2;
  localparam logic [1:0] ST_HALT  = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic        epoch_q, epoch_d;
  logic        infl_q, infl_d;
  logic [31:0] infl_pc_q, infl_pc_d;
  logic        infl_epoch_q, infl_epoch_d;
  logic        skid_valid_q, skid_valid_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] skid_ir_q, skid_ir_d;
  logic        valid_q, valid_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;

  logic        issue;
  logic        resp_ok;
  logic        accept;
  logic [31:0] fetch_addr;

  always_comb begin
    // Reset gating keeps the strobe low while reset is held.
    issue        = !reset_i && (state_q != ST_HALT) &&
                   (jmp_valid_i || (!halt_i && !stall_i));
    fetch_addr   = jmp_valid_i ? (jmp_addr_i & ~32'd3) : fetch_pc_q;
    fetch_pc_d   = issue ? (fetch_addr + 32'd4) : fetch_pc_q;
    epoch_d      = epoch_q ^ jmp_valid_i;
    infl_d       = issue;
    infl_pc_d    = fetch_addr;
    infl_epoch_d = epoch_d;

    resp_ok      = infl_q && (infl_epoch_q == epoch_q) && !jmp_valid_i;
    accept       = !valid_q || !stall_i;

    valid_d      = valid_q;
    pc_d         = pc_q;
    ir_d         = ir_q;
    skid_valid_d = skid_valid_q;
    skid_pc_d    = skid_pc_q;
    skid_ir_d    = skid_ir_q;

    if (jmp_valid_i) begin
      valid_d      = 1'b0;
      skid_valid_d = 1'b0;
    end else if (accept) begin
      if (skid_valid_q) begin
        valid_d      = 1'b1;
        pc_d         = skid_pc_q;
        ir_d         = skid_ir_q;
        skid_valid_d = resp_ok;
        skid_pc_d    = infl_pc_q;
        skid_ir_d    = imem_data_i;
      end else if (resp_ok) begin
        valid_d = 1'b1;
        pc_d    = infl_pc_q;
        ir_d    = imem_data_i;
      end else begin
        valid_d = 1'b0;
      end
    end else if (resp_ok) begin
      skid_valid_d = 1'b1;
      skid_pc_d    = infl_pc_q;
      skid_ir_d    = imem_data_i;
    end

    if (state_q == ST_HALT || halt_i) begin
      state_d = ST_HALT;
    end else if (stall_i && !jmp_valid_i) begin
      state_d = ST_STALL;
    end else begin
      state_d = ST_RUN;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= ST_IDLE;
      fetch_pc_q   <= RESET_VECTOR;
      epoch_q      <= 1'b0;
      infl_q       <= 1'b0;
      infl_pc_q    <= 32'd0;
      infl_epoch_q <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_pc_q    <= 32'd0;
      skid_ir_q    <= NOP_WORD;
      valid_q      <= 1'b0;
      pc_q         <= 32'd0;
      ir_q         <= NOP_WORD;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      epoch_q      <= epoch_d;
      infl_q       <= infl_d;
      infl_pc_q    <= infl_pc_d;
      infl_epoch_q <= infl_epoch_d;
      skid_valid_q <= skid_valid_d;
      skid_pc_q    <= skid_pc_d;
      skid_ir_q    <= skid_ir_d;
      valid_q      <= valid_d;
      pc_q         <= pc_d;
      ir_q         <= ir_d;
    end
  end

  assign imem_addr_o = fetch_addr;
  assign imem_rd_o   = issue;
  assign valid_o     = valid_q;
  assign pc_o        = pc_q;
  assign ir_o        = valid_q ? ir_q : NOP_WORD;

`ifdef FETCH_COUNTERS_EN
  logic [63:0] fetch_count_q, fetch_count_d;
  logic [31:0] flush_count_q, flush_count_d;

  always_comb begin
    fetch_count_d = fetch_count_q + {63'd0, (valid_q && !stall_i)};
    flush_count_d = flush_count_q + {31'd0, jmp_valid_i};
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      fetch_count_q <= 64'd0;
      flush_count_q <= 32'd0;
    end else begin
      fetch_count_q <= fetch_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  assign fetch_count_o = fetch_count_q;
  assign flush_count_o = flush_count_q;
`endif

endmodule
`default_nettype wire
